// File: rtl/i2c_bootloader_bridge.sv
`default_nettype none
// ============================================================================
// Module  : i2c_bootloader_bridge
// Brief   : I2C slave byte stream <-> bootloader FSM bridge with a response
//           buffer read back behind a status header.
// Revision: 1.0
// ============================================================================
module i2c_bootloader_bridge #(
    parameter int         DEPTH        = 15360,
    parameter int         STATUS_BYTES = 3,
    parameter bit         BACKPRESSURE = 1'b0,
    parameter logic [7:0] FILL_BYTE    = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bootloader_out_valid,
    input  logic [7:0]                 bootloader_out_data,
    output logic                       bootloader_out_ready,
    output logic                       bootloader_in_valid,
    output logic [7:0]                 bootloader_in_data,
    input  logic                       bootloader_in_ready,
    input  logic                       bootloader_busy,
    output logic                       bootloader_reset,
    input  logic                       i2c_read_ready,
    output logic [7:0]                 i2c_read_data,
    output logic                       i2c_read_valid,
    output logic                       i2c_write_ready,
    input  logic [7:0]                 i2c_write_data,
    input  logic                       i2c_write_valid,
    input  logic                       i2c_read,
    input  logic                       i2c_write,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);

    localparam int               PTR_W    = $clog2(DEPTH + 1);
    localparam int               ADDR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH);
    localparam logic [1:0]       HDR_LAST = 2'(STATUS_BYTES - 1);

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] write_ptr_q, write_ptr_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] read_ptr_q, read_ptr_d;
    logic [1:0]       hdr_idx_q, hdr_idx_d;
    state_t           state_q, state_d;
    logic [7:0]       ram_q;
    logic             past_end_q;
    logic             full, accept, store, fetch;
    logic [31:0]      wp_ext;
    logic [15:0]      len;

    assign bootloader_in_valid  = i2c_write_valid;
    assign bootloader_in_data   = i2c_write_data;
    assign i2c_write_ready      = bootloader_in_ready;
    assign bootloader_reset     = reset | i2c_write;
    assign fill_level           = write_ptr_q;

    assign full                 = (write_ptr_q == PTR_MAX);
    assign bootloader_out_ready = !reset && !(BACKPRESSURE && full);
    assign accept               = bootloader_out_valid && bootloader_out_ready;
    // A new write transaction discards any response byte arriving with it.
    assign store                = accept && !i2c_write && !full;

    assign wp_ext = 32'(write_ptr_q);
    assign len    = (wp_ext > 32'h0000_FFFF) ? 16'hFFFF : wp_ext[15:0];

    always_comb begin
        write_ptr_d = write_ptr_q;
        overflow_d  = overflow_q;
        if (i2c_write) begin
            write_ptr_d = '0;
            overflow_d  = 1'b0;
        end else if (accept) begin
            if (!full) begin
                write_ptr_d = write_ptr_q + PTR_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[write_ptr_q[ADDR_W-1:0]] <= bootloader_out_data;
        end
        if (fetch) begin
            ram_q      <= mem[read_ptr_q[ADDR_W-1:0]];
            past_end_q <= (read_ptr_q >= write_ptr_q);
        end
    end

    always_comb begin
        state_d        = state_q;
        hdr_idx_d      = hdr_idx_q;
        read_ptr_d     = read_ptr_q;
        i2c_read_valid = 1'b0;
        i2c_read_data  = 8'h00;
        fetch          = 1'b0;
        case (state_q)
            ST_HDR: begin
                i2c_read_valid = !reset;
                case (hdr_idx_q)
                    2'd1:    i2c_read_data = len[7:0];
                    2'd2:    i2c_read_data = len[15:8];
                    default: i2c_read_data = {bootloader_busy, overflow_q, 6'b0};
                endcase
                if (i2c_read_ready) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == HDR_LAST) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                fetch   = 1'b1;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                i2c_read_valid = !reset;
                i2c_read_data  = past_end_q ? FILL_BYTE : ram_q;
                if (i2c_read_ready) begin
                    if (read_ptr_q != PTR_MAX) begin
                        read_ptr_d = read_ptr_q + PTR_W'(1);
                    end
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_HDR;
        endcase
        // Start of a read transaction overrides any same-cycle transfer.
        if (i2c_read) begin
            read_ptr_d = '0;
            hdr_idx_d  = '0;
            state_d    = ST_HDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_ptr_q <= '0;
            overflow_q  <= 1'b0;
            read_ptr_q  <= '0;
            hdr_idx_q   <= '0;
            state_q     <= ST_HDR;
        end else begin
            write_ptr_q <= write_ptr_d;
            overflow_q  <= overflow_d;
            read_ptr_q  <= read_ptr_d;
            hdr_idx_q   <= hdr_idx_d;
            state_q     <= state_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bootloader_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_bootloader_bridge
// Brief   : Three bridge configurations driven in lockstep against a
//           transaction-level model of buffer contents and read stream.
// Revision: 1.0
// ============================================================================
module tb_i2c_bootloader_bridge;

    localparam int N  = 3;
    localparam int D0 = 15360;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, bo_valid, bi_ready, busy, rd_ready, wr_valid, rd_start, wr_start;
    logic [7:0] bo_data, wr_data;

    logic       bo_ready [N];
    logic       bi_valid [N];
    logic [7:0] bi_data  [N];
    logic       bl_reset [N];
    logic [7:0] rd_data  [N];
    logic       rd_valid [N];
    logic       wr_ready [N];
    logic [13:0] fl0;
    logic [2:0]  fl1, fl2;

    i2c_bootloader_bridge u_dut0 (
        .clk(clk), .reset(reset),
        .bootloader_out_valid(bo_valid), .bootloader_out_data(bo_data),
        .bootloader_out_ready(bo_ready[0]), .bootloader_in_valid(bi_valid[0]),
        .bootloader_in_data(bi_data[0]), .bootloader_in_ready(bi_ready),
        .bootloader_busy(busy), .bootloader_reset(bl_reset[0]),
        .i2c_read_ready(rd_ready), .i2c_read_data(rd_data[0]), .i2c_read_valid(rd_valid[0]),
        .i2c_write_ready(wr_ready[0]), .i2c_write_data(wr_data), .i2c_write_valid(wr_valid),
        .i2c_read(rd_start), .i2c_write(wr_start), .fill_level(fl0)
    );

    i2c_bootloader_bridge #(.DEPTH(4), .BACKPRESSURE(1'b0)) u_dut1 (
        .clk(clk), .reset(reset),
        .bootloader_out_valid(bo_valid), .bootloader_out_data(bo_data),
        .bootloader_out_ready(bo_ready[1]), .bootloader_in_valid(bi_valid[1]),
        .bootloader_in_data(bi_data[1]), .bootloader_in_ready(bi_ready),
        .bootloader_busy(busy), .bootloader_reset(bl_reset[1]),
        .i2c_read_ready(rd_ready), .i2c_read_data(rd_data[1]), .i2c_read_valid(rd_valid[1]),
        .i2c_write_ready(wr_ready[1]), .i2c_write_data(wr_data), .i2c_write_valid(wr_valid),
        .i2c_read(rd_start), .i2c_write(wr_start), .fill_level(fl1)
    );

    i2c_bootloader_bridge #(.DEPTH(4), .BACKPRESSURE(1'b1)) u_dut2 (
        .clk(clk), .reset(reset),
        .bootloader_out_valid(bo_valid), .bootloader_out_data(bo_data),
        .bootloader_out_ready(bo_ready[2]), .bootloader_in_valid(bi_valid[2]),
        .bootloader_in_data(bi_data[2]), .bootloader_in_ready(bi_ready),
        .bootloader_busy(busy), .bootloader_reset(bl_reset[2]),
        .i2c_read_ready(rd_ready), .i2c_read_data(rd_data[2]), .i2c_read_valid(rd_valid[2]),
        .i2c_write_ready(wr_ready[2]), .i2c_write_data(wr_data), .i2c_write_valid(wr_valid),
        .i2c_read(rd_start), .i2c_write(wr_start), .fill_level(fl2)
    );

    // Reference model: stored bytes, overflow flag, position within a read.
    int         depth [N] = '{D0, 4, 4};
    bit         bp    [N] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] mbuf  [N][D0];
    int         msize [N];
    bit         ovf   [N];
    int         pos;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input int p);
        int len;
        if (p < 3) begin
            len = (msize[i] > 65535) ? 65535 : msize[i];
            case (p)
                0:       return {busy, ovf[i], 6'b0};
                1:       return len[7:0];
                default: return len[15:8];
            endcase
        end
        return (p - 3 < msize[i]) ? mbuf[i][p-3] : 8'hFF;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            msize[i] = 0;
            ovf[i]   = 1'b0;
        end
    endtask

    task automatic check_fill();
        chk("fill_level[0]", 32'(fl0), msize[0]);
        chk("fill_level[1]", 32'(fl1), msize[1]);
        chk("fill_level[2]", 32'(fl2), msize[2]);
    endtask

    task automatic wr_pulse();
        wr_start = 1'b1;
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("bl_reset_hi[%0d]", i), bl_reset[i], 1);
        next_cycle();
        wr_start = 1'b0;
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("bl_reset_lo[%0d]", i), bl_reset[i], 0);
        model_clear();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit exp_rdy;
        bo_valid = 1'b1;
        bo_data  = b;
        #1;
        for (int i = 0; i < N; i++) begin
            exp_rdy = !(bp[i] && msize[i] == depth[i]);
            chk($sformatf("out_ready[%0d]", i), bo_ready[i], exp_rdy);
            if (exp_rdy) begin
                if (msize[i] < depth[i]) begin
                    mbuf[i][msize[i]] = b;
                    msize[i]++;
                end else begin
                    ovf[i] = 1'b1;
                end
            end
        end
        next_cycle();
        bo_valid = 1'b0;
    endtask

    task automatic start_read();
        rd_start = 1'b1;
        next_cycle();
        rd_start = 1'b0;
        pos = 0;
    endtask

    task automatic read_byte();
        int lat;
        lat = 0;
        rd_ready = 1'b1;
        #1;
        while (!rd_valid[0] && lat < 8) begin
            next_cycle();
            lat++;
        end
        chk($sformatf("rd_latency[pos%0d]", pos), lat, (pos < 3) ? 0 : 1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rd_valid[%0d]", i), rd_valid[i], 1);
            chk($sformatf("rd_data[%0d][pos%0d]", i, pos), rd_data[i], exp_byte(i, pos));
        end
        next_cycle();
        rd_ready = 1'b0;
        pos++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; bo_valid = 1'b0; bo_data = 8'h00; bi_ready = 1'b0; busy = 1'b0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_start = 1'b0; wr_start = 1'b0;
        model_clear();
        pos = 0;

        next_cycle();
        bo_valid = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_rd_valid[%0d]", i), rd_valid[i], 0);
            chk($sformatf("rst_out_ready[%0d]", i), bo_ready[i], 0);
            chk($sformatf("rst_bl_reset[%0d]", i), bl_reset[i], 1);
        end
        next_cycle();
        bo_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check_fill();
        chk("post_rst_bl_reset", bl_reset[0], 0);

        // Header only, busy set
        busy = 1'b1;
        start_read();
        repeat (3) read_byte();

        // Three-byte response, read past the end
        busy = 1'b0;
        wr_pulse();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check_fill();
        start_read();
        repeat (8) read_byte();

        // Overflow versus back-pressure on the depth-4 instances
        wr_pulse();
        for (int k = 0; k < 6; k++) send_byte(8'hA0 + 8'(k));
        check_fill();
        start_read();
        repeat (8) read_byte();
        wr_pulse();
        start_read();
        repeat (3) read_byte();

        // Command passthrough
        for (int k = 0; k < 4; k++) begin
            wr_data  = 8'($urandom);
            wr_valid = 1'($urandom);
            bi_ready = 1'($urandom);
            #1;
            chk("in_valid", bi_valid[0], wr_valid);
            chk("in_data", bi_data[0], wr_data);
            chk("wr_ready", wr_ready[0], bi_ready);
            next_cycle();
        end

        // Write-transaction start coincident with a response byte
        send_byte(8'h5A);
        bo_valid = 1'b1;
        bo_data  = 8'hAA;
        wr_start = 1'b1;
        next_cycle();
        wr_start = 1'b0;
        bo_valid = 1'b0;
        model_clear();
        #1;
        check_fill();
        start_read();
        repeat (4) read_byte();

        // Restart read while a data byte is being presented
        send_byte(8'h01); send_byte(8'h02);
        start_read();
        repeat (3) read_byte();
        next_cycle();
        chk("mid_data_valid", rd_valid[0], 1);
        chk("mid_data_byte", rd_data[0], exp_byte(0, 3));
        rd_start = 1'b1;
        next_cycle();
        rd_start = 1'b0;
        pos = 0;
        chk("restart_valid", rd_valid[0], 1);
        chk("restart_hdr0", rd_data[0], exp_byte(0, 0));
        repeat (5) read_byte();

        // Long response exercises the upper length byte
        wr_pulse();
        for (int k = 0; k < 300; k++) send_byte(8'($urandom));
        check_fill();
        start_read();
        repeat (6) read_byte();

        // Randomised mix of operations
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: wr_pulse();
                1: begin
                    int cnt;
                    cnt = $urandom_range(1, 6);
                    for (int k = 0; k < cnt; k++) send_byte(8'($urandom));
                end
                2: begin
                    busy = 1'($urandom);
                    next_cycle();
                end
                default: begin
                    int cnt;
                    cnt = $urandom_range(1, 10);
                    start_read();
                    for (int k = 0; k < cnt; k++) read_byte();
                end
            endcase
            check_fill();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
